// File: rtl/tcam_pkg.sv
// Shared defaults, sequencer state encoding and requester IDs for the TCAM
// rule sequencer and its arbiter.
package tcam_pkg;

    localparam int DEF_KEY_W    = 128;
    localparam int DEF_ENTRIES  = 16;
    localparam int DEF_ACTION_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INVAL   = 3'd1,
        ST_WR_KEY  = 3'd2,
        ST_WR_MASK = 3'd3,
        ST_WR_ACT  = 3'd4,
        ST_SETV    = 3'd5
    } seq_state_t;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_LRN = 1'b1;

endpackage

// File: rtl/tcam_rule_sequencer_if.sv
// Rule request channel shared by the CPU staging path and the learn path.
interface tcam_rule_sequencer_if
    import tcam_pkg::*;
#(
    parameter int KEY_W    = DEF_KEY_W,
    parameter int IDX_W    = $clog2(DEF_ENTRIES),
    parameter int ACTION_W = DEF_ACTION_W
);
    // A request transfers on a cycle where valid && ready. The requester holds
    // valid and every field stable until that cycle; ready never waits on valid
    // falling and is only offered while the sequencer is idle.
    logic                valid;
    logic                ready;
    logic                del;
    logic [IDX_W-1:0]    idx;
    logic [KEY_W-1:0]    key;
    logic [KEY_W-1:0]    mask;
    logic [ACTION_W-1:0] action;

    modport master (output valid, del, idx, key, mask, action, input ready);
    modport slave  (input valid, del, idx, key, mask, action, output ready);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the side served last and
// only moves when a grant is actually issued.
module rr_arb2
    import tcam_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last == SRC_CPU) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= SRC_CPU;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/tcam_rule_sequencer.sv
// Sequences atomic rule installs/deletes into the TCAM and action tables,
// keeping entry_valid low while an entry is being rewritten.
module tcam_rule_sequencer
    import tcam_pkg::*;
#(
    parameter int KEY_W    = DEF_KEY_W,
    parameter int ENTRIES  = DEF_ENTRIES,
    parameter int IDX_W    = $clog2(ENTRIES),
    parameter int ACTION_W = DEF_ACTION_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    tcam_rule_sequencer_if.slave  cpu,
    tcam_rule_sequencer_if.slave  lrn,
    input  logic                  wr_hold,
    output logic                  tcam_wr_en,
    output logic [IDX_W-1:0]      tcam_wr_addr,
    output logic                  tcam_wr_is_mask,
    output logic [KEY_W-1:0]      tcam_wr_data,
    output logic                  action_wr_en,
    output logic [IDX_W-1:0]      action_wr_addr,
    output logic [ACTION_W-1:0]   action_wr_data,
    output logic [ENTRIES-1:0]    entry_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  done_src,
    output seq_state_t            state_dbg
);

    seq_state_t          state, nxt;
    logic                grant_en;
    logic [1:0]          gnt;
    logic                take;

    logic                del_q;
    logic                src_q;
    logic [IDX_W-1:0]    idx_q;
    logic [KEY_W-1:0]    key_q;
    logic [KEY_W-1:0]    mask_q;
    logic [ACTION_W-1:0] action_q;

    logic                tcam_wr_en_d;
    logic [IDX_W-1:0]    tcam_wr_addr_d;
    logic                tcam_wr_is_mask_d;
    logic [KEY_W-1:0]    tcam_wr_data_d;
    logic                action_wr_en_d;
    logic [IDX_W-1:0]    action_wr_addr_d;
    logic [ACTION_W-1:0] action_wr_data_d;
    logic [ENTRIES-1:0]  entry_valid_d;

    assign grant_en = (state == ST_IDLE) && !wr_hold;

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     (grant_en),
        .req    ({lrn.valid, cpu.valid}),
        .gnt    (gnt)
    );

    assign cpu.ready = gnt[0];
    assign lrn.ready = gnt[1];
    assign take      = |gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            del_q    <= 1'b0;
            src_q    <= SRC_CPU;
            idx_q    <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            action_q <= '0;
        end else if (take) begin
            src_q    <= gnt[1];
            del_q    <= gnt[1] ? lrn.del    : cpu.del;
            idx_q    <= gnt[1] ? lrn.idx    : cpu.idx;
            key_q    <= gnt[1] ? lrn.key    : cpu.key;
            mask_q   <= gnt[1] ? lrn.mask   : cpu.mask;
            action_q <= gnt[1] ? lrn.action : cpu.action;
        end
    end

    // Write-port values are prepared one state early so each strobe is a
    // register output that lines up with the state it belongs to.
    always_comb begin
        nxt               = state;
        tcam_wr_en_d      = 1'b0;
        tcam_wr_addr_d    = tcam_wr_addr;
        tcam_wr_is_mask_d = tcam_wr_is_mask;
        tcam_wr_data_d    = tcam_wr_data;
        action_wr_en_d    = 1'b0;
        action_wr_addr_d  = action_wr_addr;
        action_wr_data_d  = action_wr_data;
        entry_valid_d     = entry_valid;
        case (state)
            ST_IDLE: begin
                if (take) nxt = ST_INVAL;
            end
            ST_INVAL: begin
                entry_valid_d[idx_q] = 1'b0;
                if (del_q) begin
                    nxt = ST_IDLE;
                end else begin
                    nxt               = ST_WR_KEY;
                    tcam_wr_en_d      = 1'b1;
                    tcam_wr_addr_d    = idx_q;
                    tcam_wr_is_mask_d = 1'b0;
                    tcam_wr_data_d    = key_q;
                end
            end
            ST_WR_KEY: begin
                nxt               = ST_WR_MASK;
                tcam_wr_en_d      = 1'b1;
                tcam_wr_addr_d    = idx_q;
                tcam_wr_is_mask_d = 1'b1;
                tcam_wr_data_d    = mask_q;
            end
            ST_WR_MASK: begin
                nxt              = ST_WR_ACT;
                action_wr_en_d   = 1'b1;
                action_wr_addr_d = idx_q;
                action_wr_data_d = action_q;
            end
            ST_WR_ACT: begin
                nxt = ST_SETV;
            end
            ST_SETV: begin
                entry_valid_d[idx_q] = 1'b1;
                nxt                  = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            tcam_wr_en      <= 1'b0;
            tcam_wr_addr    <= '0;
            tcam_wr_is_mask <= 1'b0;
            tcam_wr_data    <= '0;
            action_wr_en    <= 1'b0;
            action_wr_addr  <= '0;
            action_wr_data  <= '0;
            entry_valid     <= '0;
        end else begin
            state           <= nxt;
            tcam_wr_en      <= tcam_wr_en_d;
            tcam_wr_addr    <= tcam_wr_addr_d;
            tcam_wr_is_mask <= tcam_wr_is_mask_d;
            tcam_wr_data    <= tcam_wr_data_d;
            action_wr_en    <= action_wr_en_d;
            action_wr_addr  <= action_wr_addr_d;
            action_wr_data  <= action_wr_data_d;
            entry_valid     <= entry_valid_d;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_SETV) || ((state == ST_INVAL) && del_q);
    assign done_src  = done && src_q;
    assign state_dbg = state;

endmodule
